// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the control sequencer and its helpers:
//   - opcode type codes (ir0[7:6]) and SYS sub-opcodes (ir0[3:0])
//   - sequencer state encoding (also exported on the `state` port)
//   - default data-bus IDs used by fetch / jump
//   - instruction field positions inside ir0
// ---------------------------------------------------------------------------
package cpu_pkg;

  // Sequencer states; the encoding is visible on the state output.
  typedef enum logic [1:0] {
    ST_RESET_WAIT = 2'd0,
    ST_FETCH      = 2'd1,
    ST_EXEC       = 2'd2,
    ST_HALTED     = 2'd3
  } seq_state_e;

  // Opcode type field ir0[7:6].
  typedef enum logic [1:0] {
    OP_MOV    = 2'd0,
    OP_MVI    = 2'd1,
    OP_ALU    = 2'd2,
    OP_OTHERS = 2'd3
  } op_type_e;

  // SYS sub-opcodes (OTHERS with ir0[5]=0); every other code is a NOP.
  localparam logic [3:0] SYS_HLT    = 4'd0;
  localparam logic [3:0] SYS_INC_AR = 4'd1;

  // Default bus IDs.
  localparam int DEF_IR0_ID = 0;
  localparam int DEF_MEM_ID = 1;
  localparam int DEF_PC0_ID = 6;

  // Address master select values.
  localparam logic [1:0] AMID_PC = 2'd0;
  localparam logic [1:0] AMID_AR = 2'd1;

  // ir0 field positions.
  localparam int TYPE_LO  = 6;
  localparam int SRC_LO   = 3;
  localparam int DST_LO   = 0;
  localparam int CMP_BIT  = 5;  // OTHERS: 1 = conditional jump, 0 = SYS
  localparam int FLIP_BIT = 4;  // invert the selected flag
  localparam int FSEL_LO  = 2;  // 2-bit flag select
  localparam int SYS_LO   = 0;  // 4-bit SYS sub-opcode

  function automatic op_type_e op_type(input logic [7:0] ir);
    return op_type_e'(ir[TYPE_LO +: 2]);
  endfunction

  // 3-bit register field of a MOV/MVI, starting at bit `lo`.
  function automatic logic [2:0] reg_field(input logic [7:0] ir, input int lo);
    return ir[lo +: 3];
  endfunction

endpackage

// File: rtl/control_sequencer_cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Conditional-jump evaluation: picks one latched ALU flag and optionally
// inverts it.
//   status  in  STATUS_WIDTH  {sign, zero, parity, carry}
//   sel     in  2             0=carry 1=parity 2=zero 3=sign
//   flip    in  1             invert the selected flag
//   pass    out 1             jump taken
// ---------------------------------------------------------------------------
module cond_eval #(
  parameter int STATUS_WIDTH = 4
) (
  input  logic [STATUS_WIDTH-1:0] status,
  input  logic [1:0]              sel,
  input  logic                    flip,
  output logic                    pass
);

  logic flag;

  // The flag order in the status word matches the select encoding,
  // so the select is a direct bit index.
  always_comb begin
    flag = status[sel];
    pass = flag ^ flip;
  end

endmodule

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Fetch/execute control unit. FETCH reads an opcode byte from memory into
// IR0; EXEC decodes IR0 into bus master/slave IDs, address-master select
// and strobes. It supports memory wait states, an external stall (hlt),
// a HALTED state left via resume, and a retired-instruction counter.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   hlt                 external stall (level): freezes progress, drops strobes
//   resume              pulse, leaves HALTED
//   mem_ready           memory access completes this cycle
//   ir0, alu_status     instruction register and latched ALU flags
//   mid/sid/_en         data-bus master/slave IDs and decoder enables
//   amid                address master (0=PC, 1=AR)
//   pc_inr, ar_inr      PC / AR increment strobes
//   alu_en, alu_opcode  ALU strobe and operation
//   halted, state       status
//   instr_count         retired instructions (wraps)
//
// All outputs are combinational decodes of the registered state plus the
// current inputs, so strobes react to mem_ready/hlt in the same cycle.
// ---------------------------------------------------------------------------
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int ID_WIDTH     = 3,
  parameter int ALU_OP_WIDTH = 4,
  parameter int STATUS_WIDTH = 4,
  parameter int IR0_ID       = DEF_IR0_ID,
  parameter int MEM_ID       = DEF_MEM_ID,
  parameter int PC0_ID       = DEF_PC0_ID,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hlt,
  input  logic                    resume,
  input  logic                    mem_ready,
  input  logic [7:0]              ir0,
  input  logic [STATUS_WIDTH-1:0] alu_status,
  output logic [ID_WIDTH-1:0]     mid,
  output logic [ID_WIDTH-1:0]     sid,
  output logic                    mid_en,
  output logic                    sid_en,
  output logic [1:0]              amid,
  output logic                    pc_inr,
  output logic                    ar_inr,
  output logic                    alu_en,
  output logic [ALU_OP_WIDTH-1:0] alu_opcode,
  output logic                    halted,
  output logic [1:0]              state,
  output logic [CNT_WIDTH-1:0]    instr_count
);

  localparam logic [ID_WIDTH-1:0] MEM_ID_W = ID_WIDTH'(MEM_ID);
  localparam logic [ID_WIDTH-1:0] IR0_ID_W = ID_WIDTH'(IR0_ID);
  localparam logic [ID_WIDTH-1:0] PC0_ID_W = ID_WIDTH'(PC0_ID);

  seq_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Instruction fields.
  op_type_e            ir_type;
  logic [ID_WIDTH-1:0] src_id, dst_id;
  logic [3:0]          sys_op;
  logic                is_cmp, jmp_pass;
  logic                mov_mem;

  // Decode results before hlt gating.
  logic                bus_en;
  logic                pc_raw, ar_raw, alu_raw;
  logic                step_done;  // current state's work finishes this cycle
  logic                to_halt;    // EXEC is retiring a HLT
  logic                stall;

  always_comb begin
    ir_type = op_type(ir0);
    src_id  = ID_WIDTH'(reg_field(ir0, SRC_LO));
    dst_id  = ID_WIDTH'(reg_field(ir0, DST_LO));
    sys_op  = ir0[SYS_LO +: 4];
    is_cmp  = ir0[CMP_BIT];
    mov_mem = (src_id == MEM_ID_W) || (dst_id == MEM_ID_W);
  end

  cond_eval #(
    .STATUS_WIDTH(STATUS_WIDTH)
  ) u_cond_eval (
    .status (alu_status),
    .sel    (ir0[FSEL_LO +: 2]),
    .flip   (ir0[FLIP_BIT]),
    .pass   (jmp_pass)
  );

  // hlt never holds the sequencer in RESET_WAIT.
  assign stall = hlt && (state_q != ST_RESET_WAIT);

  // ---------------------------------------------------------------------
  // Output / completion decode
  // ---------------------------------------------------------------------
  always_comb begin
    mid       = '0;
    sid       = '0;
    amid      = AMID_PC;
    bus_en    = 1'b0;
    pc_raw    = 1'b0;
    ar_raw    = 1'b0;
    alu_raw   = 1'b0;
    step_done = 1'b0;
    to_halt   = 1'b0;

    unique case (state_q)
      ST_FETCH: begin
        mid       = MEM_ID_W;
        sid       = IR0_ID_W;
        bus_en    = 1'b1;
        pc_raw    = mem_ready;
        step_done = mem_ready;
      end

      ST_EXEC: begin
        unique case (ir_type)
          OP_MOV: begin
            mid       = src_id;
            sid       = dst_id;
            bus_en    = 1'b1;
            amid      = mov_mem ? AMID_AR : AMID_PC;
            step_done = !mov_mem || mem_ready;
          end
          OP_MVI: begin
            // Immediate operand is read through PC, which then advances.
            mid       = MEM_ID_W;
            sid       = dst_id;
            bus_en    = 1'b1;
            pc_raw    = mem_ready;
            step_done = mem_ready;
          end
          OP_ALU: begin
            alu_raw   = 1'b1;
            step_done = 1'b1;
          end
          OP_OTHERS: begin
            if (is_cmp) begin
              if (jmp_pass) begin
                // Load the jump target straight from memory into PC.
                mid       = MEM_ID_W;
                sid       = PC0_ID_W;
                bus_en    = 1'b1;
                step_done = mem_ready;
              end else begin
                // Not taken: step PC over the target operand.
                pc_raw    = 1'b1;
                step_done = 1'b1;
              end
            end else begin
              step_done = 1'b1;
              if (sys_op == SYS_HLT)         to_halt = 1'b1;
              else if (sys_op == SYS_INC_AR) ar_raw  = 1'b1;
            end
          end
          default: ;
        endcase
      end

      default: ;  // RESET_WAIT, HALTED: bus idle
    endcase
  end

  // Strobes are suppressed while stalled; IDs and amid keep their decode.
  always_comb begin
    mid_en      = bus_en && !stall;
    sid_en      = bus_en && !stall;
    pc_inr      = pc_raw && !stall;
    ar_inr      = ar_raw && !stall;
    alu_en      = alu_raw && !stall;
    alu_opcode  = ir0[ALU_OP_WIDTH-1:0];
    halted      = (state_q == ST_HALTED);
    state       = state_q;
    instr_count = cnt_q;
  end

  // ---------------------------------------------------------------------
  // Next state and retired-instruction counter
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!stall) begin
      unique case (state_q)
        ST_RESET_WAIT: state_d = ST_FETCH;
        ST_FETCH:      if (step_done) state_d = ST_EXEC;
        ST_EXEC: begin
          if (step_done) begin
            state_d = to_halt ? ST_HALTED : ST_FETCH;
            cnt_d   = cnt_q + CNT_WIDTH'(1);  // HLT retires too
          end
        end
        ST_HALTED:     if (resume) state_d = ST_FETCH;
        default:       state_d = ST_RESET_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET_WAIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomised scoreboard bench for control_sequencer. The driver advances a
// behavioural model each cycle and queues the expected outputs; the monitor
// compares them against the DUT half a cycle later.
module tb_control_sequencer;

  localparam int CW     = 4;     // small counter so wrap-around is exercised
  localparam int NCYC   = 4000;

  // Model state names (match the state output encoding).
  localparam int S_RW = 0, S_F = 1, S_E = 2, S_H = 3;

  logic       clk = 1'b0;
  logic       reset, hlt, resume, mem_ready;
  logic [7:0] ir0;
  logic [3:0] alu_status;

  logic [2:0]    mid, sid;
  logic          mid_en, sid_en;
  logic [1:0]    amid;
  logic          pc_inr, ar_inr, alu_en;
  logic [3:0]    alu_opcode;
  logic          halted;
  logic [1:0]    state;
  logic [CW-1:0] instr_count;

  control_sequencer #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .hlt(hlt), .resume(resume),
    .mem_ready(mem_ready), .ir0(ir0), .alu_status(alu_status),
    .mid(mid), .sid(sid), .mid_en(mid_en), .sid_en(sid_en), .amid(amid),
    .pc_inr(pc_inr), .ar_inr(ar_inr), .alu_en(alu_en),
    .alu_opcode(alu_opcode), .halted(halted), .state(state),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]    mid, sid;
    logic          mid_en, sid_en;
    logic [1:0]    amid;
    logic          pc_inr, ar_inr, alu_en;
    logic [3:0]    alu_opcode;
    logic          halted;
    logic [1:0]    state;
    logic [CW-1:0] instr_count;
  } obs_t;

  obs_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural reference: what the bus does in a given phase of an
  // instruction, and where the instruction goes next.
  function automatic void model(input int st, input logic [7:0] ir,
                                input logic [3:0] stat, input logic h,
                                input logic mr, input logic rs, input logic rst,
                                output obs_t e, output int nst, output bit retire);
    int  kind, src, dst, fsel;
    bit  en, done, go_halt, taken;
    e = '0; en = 0; done = 0; go_halt = 0; retire = 0; nst = st;
    kind = int'(ir[7:6]); src = int'(ir[5:3]); dst = int'(ir[2:0]);
    e.alu_opcode = ir[3:0];
    e.state  = st[1:0];
    e.halted = (st == S_H);
    if (st == S_RW) nst = S_F;
    else if (st == S_F) begin
      e.mid = 3'd1; e.sid = 3'd0; en = 1; e.pc_inr = mr; done = mr;
    end else if (st == S_E) begin
      if (kind == 0) begin
        e.mid = src[2:0]; e.sid = dst[2:0]; en = 1;
        e.amid = (src == 1 || dst == 1) ? 2'd1 : 2'd0;
        done = (src == 1 || dst == 1) ? mr : 1'b1;
      end else if (kind == 1) begin
        e.mid = 3'd1; e.sid = dst[2:0]; en = 1; e.pc_inr = mr; done = mr;
      end else if (kind == 2) begin
        e.alu_en = 1; done = 1;
      end else if (ir[5]) begin
        fsel  = int'(ir[3:2]);
        taken = stat[fsel] != ir[4];
        if (taken) begin e.mid = 3'd1; e.sid = 3'd6; en = 1; done = mr; end
        else       begin e.pc_inr = 1; done = 1; end
      end else begin
        done = 1;
        if (ir[3:0] == 4'd0) go_halt = 1;
        if (ir[3:0] == 4'd1) e.ar_inr = 1;
      end
    end else if (rs) nst = S_F;

    if (st == S_F && done) nst = S_E;
    if (st == S_E && done) begin nst = go_halt ? S_H : S_F; retire = 1; end
    e.mid_en = en; e.sid_en = en;
    if (h && st != S_RW) begin
      e.mid_en = 0; e.sid_en = 0; e.pc_inr = 0; e.ar_inr = 0; e.alu_en = 0;
      nst = st; retire = 0;
    end
    if (rst) begin nst = S_RW; retire = 0; end
  endfunction

  // Monitor: compare one queued expectation per cycle, away from posedge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = '{mid, sid, mid_en, sid_en, amid, pc_inr, ar_inr, alu_en,
            alu_opcode, halted, state, instr_count};
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0t got mid=%0d sid=%0d en=%b%b amid=%0d pc=%b ar=%b alu=%b op=%h hl=%b st=%0d cnt=%0d | exp mid=%0d sid=%0d en=%b%b amid=%0d pc=%b ar=%b alu=%b op=%h hl=%b st=%0d cnt=%0d",
                 $time, a.mid, a.sid, a.mid_en, a.sid_en, a.amid, a.pc_inr, a.ar_inr, a.alu_en,
                 a.alu_opcode, a.halted, a.state, a.instr_count,
                 e.mid, e.sid, e.mid_en, e.sid_en, e.amid, e.pc_inr, e.ar_inr, e.alu_en,
                 e.alu_opcode, e.halted, e.state, e.instr_count);
      end
    end
  end

  // Opcodes issued first, in order, before random ones.
  logic [7:0] dir_ops [14];
  int         dir_idx = 0;

  function automatic logic [7:0] pick_op();
    logic [7:0] op;
    if (dir_idx < 14) begin
      op = dir_ops[dir_idx];
      dir_idx++;
    end else begin
      op = 8'($urandom);
    end
    return op;
  endfunction

  initial begin
    int   m_st, m_cnt, nxt, hlt_left;
    bit   ret;
    obs_t e;
    dir_ops = '{8'h0B, 8'h4B, 8'h85, 8'hE4, 8'hE4, 8'hF4, 8'hC0, 8'hC1,
                8'hC2, 8'h08, 8'h11, 8'hD3, 8'hEC, 8'hC0};
    reset = 1'b1; hlt = 1'b0; resume = 1'b0; mem_ready = 1'b0;
    ir0 = 8'h00; alu_status = 4'h0;
    m_st = S_RW; m_cnt = 0; hlt_left = 0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      reset = (cyc < 3) || ($urandom_range(0, 299) == 0);
      if (hlt_left > 0) begin
        hlt = 1'b1; hlt_left--;
      end else if ($urandom_range(0, 19) == 0) begin
        hlt = 1'b1; hlt_left = int'($urandom_range(0, 5));
      end else begin
        hlt = 1'b0;
      end
      mem_ready  = ($urandom_range(0, 3) != 0);
      resume     = ($urandom_range(0, 5) == 0);
      alu_status = 4'($urandom);

      model(m_st, ir0, alu_status, hlt, mem_ready, resume, reset, e, nxt, ret);
      e.instr_count = CW'(m_cnt);
      exp_q.push_back(e);

      @(posedge clk); #1;
      // IR0 is loaded at the edge that completes FETCH.
      if (m_st == S_F && nxt == S_E) ir0 = pick_op();
      m_cnt = reset ? 0 : (m_cnt + (ret ? 1 : 0)) % (1 << CW);
      m_st  = nxt;
    end
    @(negedge clk); #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
